// File: rtl/board_io_ctrl.sv
// Board front end: switch synchronise/debounce with edge pulses, core reset
// sequencing (power-up hold and switch-triggered re-reset) and status LED drivers.
module board_io_ctrl #(
   parameter int unsigned N_SW            = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned RST_SW          = 1,
   parameter int unsigned RST_HOLD        = 256,
   parameter int unsigned N_LED           = 4,
   parameter int unsigned BLINK_LOG2      = 24
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [N_SW-1:0]    sw_raw,
   output logic [N_SW-1:0]    sw_level,
   output logic [N_SW-1:0]    sw_press,
   output logic [N_SW-1:0]    sw_release,
   output logic               core_rst,
   input  logic [N_LED-1:0]   led_val,
   input  logic [2*N_LED-1:0] led_mode,
   output logic [N_LED-1:0]   led
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(RST_HOLD + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HC_LAST  = HW'(RST_HOLD - 1);

   typedef enum logic [1:0] {
      HOLD     = 2'd0,
      RUN      = 2'd1,
      WAIT_REL = 2'd2
   } state_t;

   logic [N_SW-1:0] sync1;
   logic [N_SW-1:0] sync2;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
      end
   end

   // Each channel keeps its own registers; the vectors are assembled below.
   for (genvar g = 0; g < N_SW; g++) begin : g_sw
      logic [CW-1:0] cnt;
      logic          lvl;
      logic          prs;
      logic          rel;

      always_ff @(posedge CLK) begin
         if (RST) begin
            cnt <= '0;
            lvl <= 1'b0;
            prs <= 1'b0;
            rel <= 1'b0;
         end else begin
            prs <= 1'b0;
            rel <= 1'b0;
            if (sync2[g] == lvl) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               cnt <= '0;
               lvl <= sync2[g];
               prs <= sync2[g];
               rel <= ~sync2[g];
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end

      assign sw_level[g]   = lvl;
      assign sw_press[g]   = prs;
      assign sw_release[g] = rel;
   end

   state_t        state;
   state_t        state_nx;
   logic [HW-1:0] hc;
   logic [HW-1:0] hc_nx;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= HOLD;
         hc    <= '0;
      end else begin
         state <= state_nx;
         hc    <= hc_nx;
      end
   end

   always_comb begin
      state_nx = state;
      hc_nx    = hc;
      case (state)
         HOLD: begin
            hc_nx = hc + HW'(1);
            if (sw_press[RST_SW])
               state_nx = WAIT_REL;
            else if (hc == HC_LAST)
               state_nx = RUN;
         end
         RUN: begin
            if (sw_press[RST_SW])
               state_nx = WAIT_REL;
         end
         WAIT_REL: begin
            if (!sw_level[RST_SW]) begin
               state_nx = HOLD;
               hc_nx    = '0;
            end
         end
         default: begin
            state_nx = HOLD;
            hc_nx    = '0;
         end
      endcase
   end

   assign core_rst = (state != RUN);

   logic [BLINK_LOG2-1:0] bc;
   logic                  phase;

   always_ff @(posedge CLK) begin
      if (RST)
         bc <= '0;
      else
         bc <= bc + BLINK_LOG2'(1);
   end

   assign phase = bc[BLINK_LOG2-1];

   for (genvar g = 0; g < N_LED; g++) begin : g_led
      logic [1:0]            mode;
      logic [BLINK_LOG2-1:0] sc;
      logic                  lq;

      assign mode = led_mode[2*g+1:2*g];

      always_ff @(posedge CLK) begin
         if (RST) begin
            sc <= '0;
            lq <= 1'b0;
         end else begin
            sc <= '0;
            case (mode)
               2'b00: lq <= 1'b0;
               2'b01: lq <= led_val[g];
               2'b10: lq <= led_val[g] & phase;
               default: begin
                  lq <= led_val[g] | (sc != '0);
                  if (led_val[g])
                     sc <= '1;
                  else if (sc != '0)
                     sc <= sc - BLINK_LOG2'(1);
               end
            endcase
         end
      end

      assign led[g] = lq;
   end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl: debounce timing, reset sequencing and LED modes,
// with expected values worked out by hand for the small test parameters.
module tb_board_io_ctrl;

   localparam int unsigned N_SW  = 5;
   localparam int unsigned N_LED = 4;

   logic             CLK;
   logic             RST;
   logic [N_SW-1:0]  sw_raw;
   logic [N_SW-1:0]  sw_level;
   logic [N_SW-1:0]  sw_press;
   logic [N_SW-1:0]  sw_release;
   logic             core_rst;
   logic [N_LED-1:0] led_val;
   logic [7:0]       led_mode;
   logic [N_LED-1:0] led;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   board_io_ctrl #(
      .N_SW(5),
      .DEBOUNCE_CYCLES(4),
      .RST_SW(1),
      .RST_HOLD(8),
      .N_LED(4),
      .BLINK_LOG2(3)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .sw_raw(sw_raw),
      .sw_level(sw_level),
      .sw_press(sw_press),
      .sw_release(sw_release),
      .core_rst(core_rst),
      .led_val(led_val),
      .led_mode(led_mode),
      .led(led)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_ph;
      RST      = 1'b1;
      sw_raw   = '0;
      led_val  = '0;
      led_mode = '0;
      repeat (3) tick();

      check("rst_level",   32'(sw_level),   32'h0);
      check("rst_press",   32'(sw_press),   32'h0);
      check("rst_release", 32'(sw_release), 32'h0);
      check("rst_led",     32'(led),        32'h0);
      check("rst_core",    32'(core_rst),   32'h1);

      // power-up hold: high for cycles r..r+7, low from r+8
      RST = 1'b0;
      cyc = 0;
      for (int i = 0; i < 8; i++) begin
         check("hold_core_hi", 32'(core_rst), 32'h1);
         tick();
      end
      check("hold_core_lo", 32'(core_rst), 32'h0);

      // glitch of 3 cycles is rejected
      sw_raw[0] = 1'b1;
      repeat (3) tick();
      sw_raw[0] = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check("glitch_level", 32'(sw_level[0]), 32'h0);
         check("glitch_press", 32'(sw_press[0]), 32'h0);
         tick();
      end

      // held press accepted after 6 cycles, then release
      sw_raw[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("press_early", 32'(sw_level[0]), 32'h0);
      end
      tick();
      check("press_level", 32'(sw_level[0]), 32'h1);
      check("press_pulse", 32'(sw_press[0]), 32'h1);
      tick();
      check("press_one_cycle", 32'(sw_press[0]), 32'h0);
      check("press_level_hold", 32'(sw_level[0]), 32'h1);
      sw_raw[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("release_early", 32'(sw_release[0]), 32'h0);
      end
      tick();
      check("release_pulse", 32'(sw_release[0]), 32'h1);
      check("release_level", 32'(sw_level[0]), 32'h0);
      tick();
      check("release_one_cycle", 32'(sw_release[0]), 32'h0);

      // switch-triggered core reset
      check("run_before_sw", 32'(core_rst), 32'h0);
      sw_raw[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("sw_rst_pre", 32'(core_rst), 32'h0);
      end
      tick();
      check("sw_rst_press", 32'(sw_press[1]), 32'h1);
      check("sw_rst_press_core", 32'(core_rst), 32'h0);
      tick();
      check("sw_rst_rise", 32'(core_rst), 32'h1);
      for (int i = 0; i < 13; i++) begin
         tick();
         check("sw_rst_held", 32'(core_rst), 32'h1);
      end
      sw_raw[1] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("sw_rst_wait", 32'(core_rst), 32'h1);
      end
      check("sw_rst_level_fall", 32'(sw_level[1]), 32'h0);
      check("sw_rst_release", 32'(sw_release[1]), 32'h1);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("sw_rst_rehold", 32'(core_rst), 32'h1);
      end
      tick();
      check("sw_rst_done", 32'(core_rst), 32'h0);

      // blink on ch0, on ch1, blink with val 0 on ch2, off ch3
      led_val  = 4'b1011;
      led_mode = 8'b00_10_01_10;
      tick();
      for (int i = 0; i < 16; i++) begin
         exp_ph = (((cyc - 1) >> 2) & 1) != 0;
         check("blink_vec", 32'(led), {28'h0, 1'b0, 1'b0, 1'b1, exp_ph});
         tick();
      end

      // stretch: single-cycle request gives 8 high cycles
      led_val  = '0;
      led_mode = 8'b00_00_00_11;
      repeat (2) tick();
      led_val[0] = 1'b1;
      check("stretch_latency", 32'(led[0]), 32'h0);
      tick();
      led_val[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("stretch_hi", 32'(led[0]), 32'h1);
         tick();
      end
      check("stretch_end", 32'(led[0]), 32'h0);
      repeat (2) tick();

      // retrigger during the 5th high cycle restarts the 8-cycle stretch
      led_val[0] = 1'b1;
      tick();
      led_val[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("retrig_first", 32'(led[0]), 32'h1);
         if (i < 4) tick();
      end
      led_val[0] = 1'b1;
      tick();
      led_val[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("retrig_hi", 32'(led[0]), 32'h1);
         tick();
      end
      check("retrig_end", 32'(led[0]), 32'h0);

      // leaving stretch mode discards the remaining stretch
      led_val[0] = 1'b1;
      tick();
      led_val[0] = 1'b0;
      led_mode   = 8'b00_00_00_00;
      tick();
      check("mode_off", 32'(led[0]), 32'h0);
      led_mode = 8'b00_00_00_11;
      tick();
      check("stretch_cleared", 32'(led[0]), 32'h0);
      led_mode = '0;

      // RST mid-debounce (cnt=2) and mid-HOLD
      sw_raw[2] = 1'b1;
      repeat (4) tick();
      RST = 1'b1;
      tick();
      check("abort_level", 32'(sw_level), 32'h0);
      check("abort_press", 32'(sw_press), 32'h0);
      check("abort_core",  32'(core_rst), 32'h1);
      check("abort_led",   32'(led),      32'h0);
      RST = 1'b0;
      repeat (3) tick();
      check("midhold_core", 32'(core_rst), 32'h1);
      RST = 1'b1;
      tick();
      check("midhold_rst_core", 32'(core_rst), 32'h1);
      check("midhold_rst_level", 32'(sw_level[2]), 32'h0);
      RST = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         check("rerun_level", 32'(sw_level[2]), 32'(i >= 6));
         check("rerun_press", 32'(sw_press[2]), 32'(i == 6));
         check("rerun_core",  32'(core_rst),    32'(i < 8));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
